burst_addr_gen: RTL and testbench

Parametrised burst address generator for the I2C/Triple-DES data path buffer memory. A single `start` pulse launches a burst of `burst_len` beats from a programmable base address:
- Write mode steps the address up by `STRIDE` and asserts `write_en`.
- Read mode steps the address down by `STRIDE` and asserts `read_en`.

The block adds memory back-pressure (`mem_ready`), abort, and a completion pulse.

---
 rtl/addr_gen_pkg.sv | 15 +
 rtl/burst_addr_gen.sv | 135 +++++++++++++
 tb/tb_burst_addr_gen.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_gen_pkg.sv
// Shared types for the burst address generator.
// FSM states and transfer-direction constants.
package addr_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ  = 1'b1;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address generator for the buffer memory.
// Steps up (write) or down (read) by STRIDE per accepted beat.
module burst_addr_gen
  import addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned STRIDE = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              rw_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W:0]    burst_len,
  input  logic              mem_ready,
  input  logic              abort,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic              read_en,
  output logic              busy,
  output logic              done,
  output logic [LEN_W:0]    beats_done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W:0]      beats_q, beats_d;
  logic [LEN_W:0]      len_q, len_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic [LEN_W:0]      beats_inc;

  assign accept    = (wen_q | ren_q) & mem_ready;
  assign beats_inc = beats_q + 1'b1;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    len_d   = len_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = burst_len;
          addr_d  = base_addr;
          beats_d = '0;
          busy_d  = 1'b1;
          if (burst_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            wen_d   = 1'b0;
            ren_d   = 1'b0;
          end else if (rw_mode == MODE_READ) begin
            state_d = READ;
            wen_d   = 1'b0;
            ren_d   = 1'b1;
          end else begin
            state_d = WRITE;
            wen_d   = 1'b1;
            ren_d   = 1'b0;
          end
        end
      end
      WRITE, READ: begin
        if (accept) begin
          beats_d = beats_inc;
          if (state_q == WRITE)
            addr_d = addr_q + STEP;
          else
            addr_d = addr_q - STEP;
        end
        if (abort || (accept && beats_inc == len_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      len_q   <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      len_q   <= len_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign address    = addr_q;
  assign write_en   = wen_q;
  assign read_en    = ren_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign beats_done = beats_q;

endmodule

// File: tb/tb_burst_addr_gen.sv
// Testbench for burst_addr_gen.
// Randomised bursts checked against an arithmetic address model.
module tb_burst_addr_gen;

  localparam int ADDR_W = 16;
  localparam int LEN_W  = 3;
  localparam int STRIDE = 1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic              rw_mode;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W:0]    burst_len;
  logic              mem_ready;
  logic              abort;
  logic [ADDR_W-1:0] address;
  logic              write_en;
  logic              read_en;
  logic              busy;
  logic              done;
  logic [LEN_W:0]    beats_done;

  int tests = 0;
  int fails = 0;

  burst_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W),
    .STRIDE(STRIDE)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .rw_mode   (rw_mode),
    .base_addr (base_addr),
    .burst_len (burst_len),
    .mem_ready (mem_ready),
    .abort     (abort),
    .address   (address),
    .write_en  (write_en),
    .read_en   (read_en),
    .busy      (busy),
    .done      (done),
    .beats_done(beats_done)
  );

  always #5 clk = ~clk;

  // Address of beat k: base plus/minus k strides, wrapped.
  function automatic logic [ADDR_W-1:0] exp_addr(
    input bit m, input logic [ADDR_W-1:0] b, input int k);
    logic [31:0] v;
    if (m) v = 32'(b) - 32'(k * STRIDE);
    else   v = 32'(b) + 32'(k * STRIDE);
    return v[ADDR_W-1:0];
  endfunction

  // Launch one burst, drive mem_ready/abort, check every cycle.
  task automatic run_burst(
    input bit m, input logic [ADDR_W-1:0] b, input int len,
    input bit rnd, input int stall_k, input int stall_n,
    input int abort_k, input bit poke,
    output int en_cyc, output int beats);
    int k, stalls, cyc;
    bit rdy, ab;
    logic [LEN_W:0] kk;
    logic [ADDR_W-1:0] ea;
    k = 0; stalls = 0; cyc = 0; en_cyc = 0; ab = 0;
    @(negedge clk);
    start = 1'b1; rw_mode = m; base_addr = b;
    burst_len = len[LEN_W:0]; mem_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base_addr = ADDR_W'($urandom);
    burst_len = (LEN_W+1)'($urandom);
    rw_mode = ~m;
    while (len > 0) begin
      ea = exp_addr(m, b, k);
      kk = k[LEN_W:0];
      tests++;
      if ({write_en, read_en, busy, done} !== {~m, m, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL beat_ctl: got we/re/busy/done=%b%b%b%b want %b%b10",
                 write_en, read_en, busy, done, ~m, m);
      end
      tests++;
      if (address !== ea) begin
        fails++;
        $display("FAIL beat_addr: got %h want %h (k=%0d)", address, ea, k);
      end
      tests++;
      if (beats_done !== kk) begin
        fails++;
        $display("FAIL beat_count: got %0d want %0d", beats_done, kk);
      end
      if (write_en || read_en) en_cyc++;
      if (k == stall_k && stalls < stall_n) begin
        rdy = 1'b0; stalls++;
      end else if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      ab = (abort_k > 0) && rdy && (k + 1 == abort_k);
      mem_ready = rdy;
      abort = ab;
      if (poke) begin
        start = 1'($urandom);
        base_addr = ADDR_W'($urandom);
        burst_len = (LEN_W+1)'($urandom);
      end
      @(negedge clk);
      if (rdy) k++;
      cyc++;
      if (k == len || ab) break;
      if (cyc > 200) begin
        tests++; fails++;
        $display("FAIL burst_timeout: got %0d cycles want <=200", cyc);
        break;
      end
    end
    mem_ready = 1'b0; abort = 1'b0; start = 1'b0;
    ea = exp_addr(m, b, k);
    kk = k[LEN_W:0];
    tests++;
    if ({write_en, read_en, busy, done} !== 4'b0011) begin
      fails++;
      $display("FAIL done_ctl: got we/re/busy/done=%b%b%b%b want 0011",
               write_en, read_en, busy, done);
    end
    tests++;
    if (address !== ea || beats_done !== kk) begin
      fails++;
      $display("FAIL done_state: got addr=%h beats=%0d want addr=%h beats=%0d",
               address, beats_done, ea, kk);
    end
    @(negedge clk);
    tests++;
    if ({write_en, read_en, busy, done} !== 4'b0000) begin
      fails++;
      $display("FAIL idle_ctl: got we/re/busy/done=%b%b%b%b want 0000",
               write_en, read_en, busy, done);
    end
    tests++;
    if (address !== ea || beats_done !== kk) begin
      fails++;
      $display("FAIL idle_hold: got addr=%h beats=%0d want addr=%h beats=%0d",
               address, beats_done, ea, kk);
    end
    beats = k;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; rw_mode = 1'b0; base_addr = '0;
    burst_len = '0; mem_ready = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({address, write_en, read_en, busy, done, beats_done} !== '0) begin
      fails++;
      $display("FAIL reset_state: got addr=%h we=%b re=%b busy=%b done=%b beats=%0d want all 0",
               address, write_en, read_en, busy, done, beats_done);
    end
  endtask

  task automatic test_write();
    int en, bt;
    run_burst(1'b0, 16'h0010, 8, 1'b0, -1, 0, 0, 1'b0, en, bt);
    tests++;
    if (en !== 8 || bt !== 8 || address !== 16'h0018) begin
      fails++;
      $display("FAIL write_burst: got en=%0d beats=%0d addr=%h want 8 8 0018",
               en, bt, address);
    end
  endtask

  task automatic test_read_wrap();
    int en, bt;
    run_burst(1'b1, 16'h0003, 5, 1'b0, -1, 0, 0, 1'b0, en, bt);
    tests++;
    if (en !== 5 || address !== 16'hFFFE) begin
      fails++;
      $display("FAIL read_wrap: got en=%0d addr=%h want 5 FFFE", en, address);
    end
  endtask

  task automatic test_stall();
    int en, bt;
    run_burst(1'b0, 16'h0100, 4, 1'b0, 1, 3, 0, 1'b0, en, bt);
    tests++;
    if (en !== 7 || beats_done !== 4'd4) begin
      fails++;
      $display("FAIL stall: got en=%0d beats=%0d want 7 4", en, beats_done);
    end
  endtask

  task automatic test_abort();
    int en, bt;
    run_burst(1'b1, 16'h0040, 8, 1'b0, -1, 0, 3, 1'b0, en, bt);
    tests++;
    if (bt !== 3 || beats_done !== 4'd3 || address !== 16'h003D) begin
      fails++;
      $display("FAIL abort: got beats=%0d addr=%h want 3 003D", beats_done, address);
    end
  endtask

  task automatic test_corner_starts();
    int en, bt;
    run_burst(1'b0, 16'h1234, 0, 1'b0, -1, 0, 0, 1'b0, en, bt);
    tests++;
    if (en !== 0 || address !== 16'h1234 || beats_done !== 4'd0) begin
      fails++;
      $display("FAIL len_zero: got en=%0d addr=%h beats=%0d want 0 1234 0",
               en, address, beats_done);
    end
    run_burst(1'b0, 16'h2000, 6, 1'b0, -1, 0, 0, 1'b1, en, bt);
    tests++;
    if (en !== 6 || address !== 16'h2006) begin
      fails++;
      $display("FAIL start_ignored: got en=%0d addr=%h want 6 2006", en, address);
    end
  endtask

  task automatic test_async_reset();
    int en, bt;
    bit seen;
    @(negedge clk);
    start = 1'b1; rw_mode = 1'b0; base_addr = 16'h0500; burst_len = 4'd8;
    mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    tests++;
    if ({address, write_en, read_en, busy, done, beats_done} !== '0) begin
      fails++;
      $display("FAIL async_reset: got addr=%h we=%b re=%b busy=%b done=%b beats=%0d want all 0",
               address, write_en, read_en, busy, done, beats_done);
    end
    @(negedge clk);
    n_rst = 1'b1;
    mem_ready = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || write_en) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_done: got activity=%b want 0", seen);
    end
    run_burst(1'b0, 16'h0700, 3, 1'b0, -1, 0, 0, 1'b0, en, bt);
    tests++;
    if (en !== 3 || address !== 16'h0703) begin
      fails++;
      $display("FAIL post_reset: got en=%0d addr=%h want 3 0703", en, address);
    end
  endtask

  task automatic test_random();
    int en, bt, len, ak, want;
    bit m;
    logic [ADDR_W-1:0] b;
    for (int i = 0; i < 12; i++) begin
      m = 1'($urandom);
      b = ADDR_W'($urandom);
      len = $urandom_range(0, 8);
      ak = ($urandom_range(0, 2) == 0 && len > 0) ? $urandom_range(1, len) : 0;
      want = (ak > 0) ? ak : len;
      run_burst(m, b, len, 1'b1, -1, 0, ak, 1'($urandom), en, bt);
      tests++;
      if (bt !== want || address !== exp_addr(m, b, want)) begin
        fails++;
        $display("FAIL random_burst: got beats=%0d addr=%h want %0d %h",
                 bt, address, want, exp_addr(m, b, want));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_stall();
    test_abort();
    test_corner_starts();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
